// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared definitions for the alarm controller: FSM state
//               encoding, one-hot key codes and time-field limits.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    // Key codes as delivered by the debounced button path (one-hot).
    localparam logic [4:0] KEY_UP    = 5'b10000;
    localparam logic [4:0] KEY_LEFT  = 5'b01000;
    localparam logic [4:0] KEY_MID   = 5'b00100;
    localparam logic [4:0] KEY_DOWN  = 5'b00010;
    localparam logic [4:0] KEY_RIGHT = 5'b00001;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Up/down counter over 0..MAX with wrap-around in both
//               directions and a parameterised synchronous reset value.
//   clk   in  1  clock
//   rst   in  1  synchronous active-high reset (loads RST_VAL)
//   en    in  1  qualifies inc/dec
//   inc   in  1  step up, MAX wraps to 0
//   dec   in  1  step down, 0 wraps to MAX (inc wins if both set)
//   count out W  current value
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int MAX     = 59,
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] C_MAX = W'(MAX);
    localparam logic [W-1:0] C_RST = W'(RST_VAL);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= C_RST;
        end else if (en && inc) begin
            r_count <= (r_count == C_MAX) ? '0 : r_count + 1'b1;
        end else if (en && dec) begin
            r_count <= (r_count == '0) ? C_MAX : r_count - 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ctrl
// Description : Alarm controller. Holds an editable HH:MM alarm time, rings
//               when the live clock reaches HH:MM:00, supports snooze and
//               dismiss, and drives a gated buzzer square wave.
//   clk, rst          clock, synchronous active-high reset
//   cur_hours/minutes/seconds  live time from the time-keeping block
//   alarm_en          level; 0 forces IDLE
//   set_mode          level; 1 = alarm edit mode
//   key_pulse[4:0]    one-cycle keys: up, left, mid, down, right
//   alarm_hours/minutes  stored alarm time
//   edit_sel          0 = minutes field, 1 = hours field
//   armed, ringing    registered state flags
//   buzzer            square wave while ringing, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int BUZZ_DIV    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic       alarm_en,
    input  logic       set_mode,
    input  logic [4:0] key_pulse,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       edit_sel,
    output logic       armed,
    output logic       ringing,
    output logic       buzzer
);

    localparam int RING_W = $clog2(RING_SECS + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
    localparam int DIV_W  = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

    localparam logic [RING_W-1:0] C_RING_LOAD = RING_W'(RING_SECS);
    localparam logic [SNZ_W-1:0]  C_SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(BUZZ_DIV - 1);

    alarm_state_t      r_state;
    logic [5:0]        r_prev_sec;
    logic [RING_W-1:0] r_ring_cnt;
    logic [SNZ_W-1:0]  r_snooze_cnt;
    logic [DIV_W-1:0]  r_div;
    logic              r_armed;
    logic              r_ringing;
    logic              r_buzzer;
    logic              r_edit_sel;

    logic w_tick;
    logic w_match;
    logic w_edit;
    logic w_key_up, w_key_left, w_key_mid, w_key_down, w_key_right;

    // Exact-equality decode: any multi-bit key pattern matches nothing.
    assign w_key_up    = (key_pulse == KEY_UP);
    assign w_key_left  = (key_pulse == KEY_LEFT);
    assign w_key_mid   = (key_pulse == KEY_MID);
    assign w_key_down  = (key_pulse == KEY_DOWN);
    assign w_key_right = (key_pulse == KEY_RIGHT);

    // A change of the seconds value marks a new second, including jumps
    // caused by editing the live clock.
    assign w_tick  = (cur_seconds != r_prev_sec);
    assign w_match = w_tick && (cur_seconds == 6'd0) &&
                     (cur_hours == alarm_hours) &&
                     (cur_minutes == alarm_minutes) && !set_mode;
    assign w_edit  = set_mode && ((r_state == IDLE) || (r_state == ARMED));

    // Loaded during reset too, so releasing reset never produces a tick.
    always_ff @(posedge clk) begin
        r_prev_sec <= cur_seconds;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edit_sel <= 1'b0;
        end else if (w_edit && (w_key_left || w_key_right)) begin
            r_edit_sel <= ~r_edit_sel;
        end
    end

    wrap_counter #(.MAX(MAX_HOUR), .W(5), .RST_VAL(7)) u_hours (
        .clk   (clk),
        .rst   (rst),
        .en    (w_edit && r_edit_sel),
        .inc   (w_key_up),
        .dec   (w_key_down),
        .count (alarm_hours)
    );

    wrap_counter #(.MAX(MAX_MIN), .W(6), .RST_VAL(0)) u_minutes (
        .clk   (clk),
        .rst   (rst),
        .en    (w_edit && !r_edit_sel),
        .inc   (w_key_up),
        .dec   (w_key_down),
        .count (alarm_minutes)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_div        <= '0;
            r_armed      <= 1'b0;
            r_ringing    <= 1'b0;
            r_buzzer     <= 1'b0;
        end else begin
            // Buzzer and divider rest at 0 unless a ringing branch below
            // keeps them running.
            r_div    <= '0;
            r_buzzer <= 1'b0;
            if (!alarm_en) begin
                r_state   <= IDLE;
                r_armed   <= 1'b0;
                r_ringing <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= ARMED;
                        r_armed <= 1'b1;
                    end
                    ARMED: begin
                        if (w_match) begin
                            r_state    <= RINGING;
                            r_ring_cnt <= C_RING_LOAD;
                            r_armed    <= 1'b0;
                            r_ringing  <= 1'b1;
                            r_buzzer   <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (w_key_mid) begin
                            r_state      <= SNOOZE;
                            r_snooze_cnt <= C_SNZ_LOAD;
                            r_ringing    <= 1'b0;
                        end else if (w_key_down ||
                                     (w_tick && r_ring_cnt == RING_W'(1))) begin
                            r_state   <= ARMED;
                            r_armed   <= 1'b1;
                            r_ringing <= 1'b0;
                        end else begin
                            if (w_tick) begin
                                r_ring_cnt <= r_ring_cnt - 1'b1;
                            end
                            if (r_div == C_DIV_LAST) begin
                                r_buzzer <= ~r_buzzer;
                            end else begin
                                r_div    <= r_div + 1'b1;
                                r_buzzer <= r_buzzer;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (w_key_down) begin
                            r_state <= ARMED;
                            r_armed <= 1'b1;
                        end else if (w_tick) begin
                            if (r_snooze_cnt == SNZ_W'(1)) begin
                                r_state    <= RINGING;
                                r_ring_cnt <= C_RING_LOAD;
                                r_ringing  <= 1'b1;
                                r_buzzer   <= 1'b1;
                            end else begin
                                r_snooze_cnt <= r_snooze_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_armed   <= 1'b0;
                        r_ringing <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign edit_sel = r_edit_sel;
    assign armed    = r_armed;
    assign ringing  = r_ringing;
    assign buzzer   = r_buzzer;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ctrl
// Description : Self-checking bench for alarm_ctrl. A behavioural model
//               tracks the alarm time as plain integers, the remaining ring
//               and snooze seconds, and the cycles spent ringing (from which
//               the buzzer level follows); it is compared with the DUT every
//               cycle. Directed scenarios add literal expectations, followed
//               by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int BUZZ_DIV    = 4;

    localparam logic [4:0] K_UP    = 5'b10000;
    localparam logic [4:0] K_LEFT  = 5'b01000;
    localparam logic [4:0] K_MID   = 5'b00100;
    localparam logic [4:0] K_DOWN  = 5'b00010;
    localparam logic [4:0] K_RIGHT = 5'b00001;

    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic       alarm_en;
    logic       set_mode;
    logic [4:0] key_pulse;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       edit_sel;
    logic       armed;
    logic       ringing;
    logic       buzzer;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .BUZZ_DIV    (BUZZ_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cur_hours     (cur_hours),
        .cur_minutes   (cur_minutes),
        .cur_seconds   (cur_seconds),
        .alarm_en      (alarm_en),
        .set_mode      (set_mode),
        .key_pulse     (key_pulse),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .edit_sel      (edit_sel),
        .armed         (armed),
        .ringing       (ringing),
        .buzzer        (buzzer)
    );

    // ---------------- behavioural model ----------------
    int m_state   = M_IDLE;
    int m_ah      = 7;
    int m_am      = 0;
    int m_sel     = 0;
    int m_ring    = 0;   // seconds of ringing left
    int m_snz     = 0;   // seconds of snooze left
    int m_ringcyc = 0;   // clock cycles since ringing (re)started
    int m_prev    = 0;

    always @(posedge clk) begin
        bit tick, match, one, entered, edit;
        int k;
        tick    = (int'(cur_seconds) != m_prev);
        m_prev  = int'(cur_seconds);
        entered = 1'b0;
        if (rst) begin
            m_state = M_IDLE; m_ah = 7; m_am = 0; m_sel = 0;
            m_ring = 0; m_snz = 0; m_ringcyc = 0;
        end else begin
            one = ($countones(key_pulse) == 1);
            k   = one ? int'(key_pulse) : 0;
            match = tick && cur_seconds == 0 && int'(cur_hours) == m_ah &&
                    int'(cur_minutes) == m_am && !set_mode;
            edit = set_mode && (m_state == M_IDLE || m_state == M_ARMED);
            if (edit) begin
                if (k == int'(K_LEFT) || k == int'(K_RIGHT)) m_sel = 1 - m_sel;
                if (k == int'(K_UP)) begin
                    if (m_sel == 1) m_ah = (m_ah + 1) % 24; else m_am = (m_am + 1) % 60;
                end
                if (k == int'(K_DOWN)) begin
                    if (m_sel == 1) m_ah = (m_ah + 23) % 24; else m_am = (m_am + 59) % 60;
                end
            end
            if (!alarm_en) begin
                m_state = M_IDLE;
            end else begin
                case (m_state)
                    M_IDLE:  m_state = M_ARMED;
                    M_ARMED: if (match) begin
                        m_state = M_RING; m_ring = RING_SECS; entered = 1'b1;
                    end
                    M_RING: begin
                        if (k == int'(K_MID)) begin
                            m_state = M_SNOOZE; m_snz = SNOOZE_SECS;
                        end else if (k == int'(K_DOWN)) begin
                            m_state = M_ARMED;
                        end else if (tick) begin
                            m_ring = m_ring - 1;
                            if (m_ring == 0) m_state = M_ARMED;
                        end
                    end
                    default: begin
                        if (k == int'(K_DOWN)) begin
                            m_state = M_ARMED;
                        end else if (tick) begin
                            m_snz = m_snz - 1;
                            if (m_snz == 0) begin
                                m_state = M_RING; m_ring = RING_SECS; entered = 1'b1;
                            end
                        end
                    end
                endcase
            end
            if (m_state == M_RING) m_ringcyc = entered ? 0 : m_ringcyc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("alarm_hours", int'(alarm_hours), m_ah);
            check("alarm_minutes", int'(alarm_minutes), m_am);
            check("edit_sel", int'(edit_sel), m_sel);
            check("armed", int'(armed), int'(m_state == M_ARMED));
            check("ringing", int'(ringing), int'(m_state == M_RING));
            check("buzzer", int'(buzzer),
                  int'(m_state == M_RING && ((m_ringcyc / BUZZ_DIV) % 2) == 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hours   = 5'(h);
        cur_minutes = 6'(m);
        cur_seconds = 6'(s);
    endtask

    task automatic adv_sec();
        int h, m, s;
        h = int'(cur_hours); m = int'(cur_minutes); s = int'(cur_seconds) + 1;
        if (s == 60) begin s = 0; m++; end
        if (m == 60) begin m = 0; h++; end
        if (h == 24) h = 0;
        set_time(h, m, s);
    endtask

    task automatic tick();
        adv_sec();
        step();
    endtask

    task automatic press(input logic [4:0] k);
        key_pulse = k;
        step();
        key_pulse = 5'd0;
    endtask

    initial begin
        rst = 1'b1; alarm_en = 1'b0; set_mode = 1'b0; key_pulse = 5'd0;
        set_time(6, 59, 50);
        step();
        chk_en = 1'b1;
        step();
        check("rst_hours", int'(alarm_hours), 7);
        check("rst_minutes", int'(alarm_minutes), 0);
        check("rst_ringing", int'(ringing), 0);
        check("rst_armed", int'(armed), 0);

        rst = 1'b0; alarm_en = 1'b1;
        step();
        check("arm_after_en", int'(armed), 1);

        repeat (10) tick();               // reaches 07:00:00
        check("ring_at_0700", int'(ringing), 1);
        check("buzz_at_0700", int'(buzzer), 1);

        press(K_MID);
        check("snooze_not_ringing", int'(ringing), 0);
        repeat (SNOOZE_SECS - 1) tick();
        check("snooze_299", int'(ringing), 0);
        tick();
        check("snooze_300_rings", int'(ringing), 1);

        repeat (RING_SECS - 1) tick();
        check("ring_59", int'(ringing), 1);
        tick();
        check("timeout_armed", int'(armed), 1);
        check("timeout_ringing", int'(ringing), 0);
        check("timeout_buzzer", int'(buzzer), 0);

        set_time(6, 59, 59); step();      // next day
        set_time(7, 0, 0);   step();
        check("next_day_ring", int'(ringing), 1);
        press(K_DOWN);
        check("dismiss_armed", int'(armed), 1);

        set_mode = 1'b1; step();
        press(K_LEFT);
        check("sel_hours", int'(edit_sel), 1);
        repeat (8) press(K_DOWN);
        check("hours_23", int'(alarm_hours), 23);
        press(K_RIGHT);
        press(K_DOWN);
        check("minutes_59", int'(alarm_minutes), 59);
        press(K_LEFT);
        press(K_UP);
        check("hours_wrap_0", int'(alarm_hours), 0);
        press(K_RIGHT);
        press(K_UP);
        check("minutes_wrap_0", int'(alarm_minutes), 0);
        press(K_DOWN);
        check("minutes_back_59", int'(alarm_minutes), 59);
        press(5'b10100);
        check("multi_key_hours", int'(alarm_hours), 0);
        check("multi_key_minutes", int'(alarm_minutes), 59);

        set_mode = 1'b0;
        set_time(0, 58, 59); step();
        set_time(0, 59, 0); alarm_en = 1'b0; step();
        check("en_drop_ringing", int'(ringing), 0);
        check("en_drop_armed", int'(armed), 0);
        alarm_en = 1'b1; step();

        set_time(0, 58, 59); step();
        set_time(0, 59, 0);  step();
        check("ring_0059", int'(ringing), 1);
        press(5'b00110);
        check("mid_down_ignored", int'(ringing), 1);
        repeat (2) step();

        rst = 1'b1; cur_seconds = 6'd30; step();
        check("midring_rst_ringing", int'(ringing), 0);
        check("midring_rst_buzzer", int'(buzzer), 0);
        check("midring_rst_hours", int'(alarm_hours), 7);
        rst = 1'b0; step();
        check("post_rst_armed", int'(armed), 1);

        // Randomized phase.
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 60)       key_pulse = 5'(1 << $urandom_range(0, 4));
            else if (r < 90)  key_pulse = 5'($urandom_range(1, 31));
            else              key_pulse = 5'd0;
            r = int'($urandom_range(0, 999));
            if (r < 15) set_mode = ~set_mode;
            r = int'($urandom_range(0, 999));
            if (alarm_en && r < 8) alarm_en = 1'b0;
            else if (!alarm_en && r < 250) alarm_en = 1'b1;
            r = int'($urandom_range(0, 999));
            if (r < 400)      adv_sec();
            else if (r < 410) set_time(m_ah, m_am, 0);
            else if (r < 420) set_time(m_ah, (m_am + 59) % 60, 59);
            rst = ($urandom_range(0, 999) < 3);
            step();
        end
        rst = 1'b0; key_pulse = 5'd0;
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
